// File: rtl/ef3_input_sequencer.sv
// EF3 input sequencer: synchronize and debounce the DE-board switches and keys,
// then drive abcd from the switches or from a free-running / single-step walker.
module ef3_input_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int STEP_CYCLES     = 25000000
) (
  input  logic       CLOCK_50,
  input  logic       rst_n,
  input  logic [3:0] SW,
  input  logic       mode_sw,
  input  logic [1:0] KEY,
  output logic [3:0] abcd,
  output logic       changed,
  output logic       wrap,
  output logic [1:0] state
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int PW = $clog2(STEP_CYCLES);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PS_LAST = PW'(STEP_CYCLES - 1);
  // Bit order {KEY[1], KEY[0], mode_sw, SW[3:0]}; keys idle high.
  localparam logic [6:0] IN_RST = 7'b110_0000;

  typedef enum logic [1:0] {
    ST_MANUAL = 2'b00,
    ST_PAUSE  = 2'b01,
    ST_RUN    = 2'b10
  } state_e;

  logic [6:0]         raw;
  logic [6:0]         sync1_q;
  logic [6:0]         sync2_q;
  logic [6:0]         db_q, db_d;
  logic [6:0][DW-1:0] cnt_q, cnt_d;
  logic [1:0]         key_prev_q;
  logic               step_p;
  logic               run_p;
  logic               mode;

  state_e      state_q, state_d;
  logic [3:0]  walker_q, walker_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]  abcd_q, abcd_d;
  logic        changed_q, changed_d;
  logic        wrap_q, wrap_d;
  logic        inc;

  assign raw = {KEY, mode_sw, SW};

  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 7; i++) begin
      if (sync2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_LAST) begin
        db_d[i]  = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      sync1_q    <= IN_RST;
      sync2_q    <= IN_RST;
      db_q       <= IN_RST;
      cnt_q      <= '0;
      key_prev_q <= 2'b11;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      db_q       <= db_d;
      cnt_q      <= cnt_d;
      key_prev_q <= db_q[6:5];
    end
  end

  // Press pulses fire on the debounced 1->0 edge only.
  assign step_p = key_prev_q[0] & ~db_q[5];
  assign run_p  = key_prev_q[1] & ~db_q[6];
  assign mode   = db_q[4];

  always_comb begin
    state_d  = state_q;
    walker_d = walker_q;
    presc_d  = presc_q;
    inc      = 1'b0;
    unique case (state_q)
      ST_MANUAL: begin
        if (mode) begin
          state_d  = ST_PAUSE;
          walker_d = '0;
        end
      end
      ST_PAUSE: begin
        if (!mode) begin
          state_d = ST_MANUAL;
        end else begin
          inc = step_p;
          if (run_p) begin
            state_d = ST_RUN;
            presc_d = '0;
          end
        end
      end
      ST_RUN: begin
        if (!mode) begin
          state_d = ST_MANUAL;
        end else begin
          if (presc_q == PS_LAST) begin
            inc     = 1'b1;
            presc_d = '0;
          end else begin
            presc_d = presc_q + 1'b1;
          end
          if (run_p) state_d = ST_PAUSE;
        end
      end
      default: state_d = ST_MANUAL;
    endcase
    if (inc) walker_d = walker_q + 4'd1;
    wrap_d    = inc & (walker_q == 4'hF);
    abcd_d    = (state_d == ST_MANUAL) ? db_q[3:0] : walker_d;
    changed_d = (abcd_d != abcd_q);
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      state_q   <= ST_MANUAL;
      walker_q  <= '0;
      presc_q   <= '0;
      abcd_q    <= '0;
      changed_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      walker_q  <= walker_d;
      presc_q   <= presc_d;
      abcd_q    <= abcd_d;
      changed_q <= changed_d;
      wrap_q    <= wrap_d;
    end
  end

  assign abcd    = abcd_q;
  assign changed = changed_q;
  assign wrap    = wrap_q;
  assign state   = state_q;

endmodule
